// File: rtl/aes_round_stage.sv
// aes_round_stage: ROUNDS_PER_STAGE AES rounds on NUM_LANES 128-bit lanes,
// behind a two-slot valid/ready skid buffer with key/sideband passthrough.
module aes_round_stage #(
  parameter int NUM_LANES        = 3,
  parameter int ROUNDS_PER_STAGE = 1,
  parameter int KEY_BITS         = 128,
  parameter int SIDEBAND_W       = 520,
  localparam int NR   = (KEY_BITS == 256) ? 14 : 10,
  localparam int KS_W = 128 * (NR + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [0:128*NUM_LANES-1]  i_data,
  input  logic [0:4*NUM_LANES-1]    i_round,
  input  logic [0:KS_W-1]           i_key_schedule,
  input  logic [0:SIDEBAND_W-1]     i_sideband,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [0:128*NUM_LANES-1]  o_data,
  output logic [0:4*NUM_LANES-1]    o_round,
  output logic [0:KS_W-1]           o_key_schedule,
  output logic [0:SIDEBAND_W-1]     o_sideband
);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_round_stage: KEY_BITS must be 128 or 256");
  end

  localparam int DW = 128 * NUM_LANES;
  localparam int RW = 4 * NUM_LANES;
  localparam logic [4:0] NR5 = 5'(NR);
  localparam logic [4:0] NR1 = 5'(NR + 1);

  typedef struct packed {
    logic [0:DW-1]         data;
    logic [0:RW-1]         rnd;
    logic [0:KS_W-1]       ks;
    logic [0:SIDEBAND_W-1] sb;
  } beat_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  function automatic logic [7:0] xt(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^
           (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse as a^254 (zero maps to zero), then the affine map.
  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] t;
    logic [7:0] v;
    t = a;
    v = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gmul(t, t);
      v = gmul(v, t);
    end
    return v ^ {v[6:0], v[7]}
             ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]}
             ^ 8'h63;
  endfunction

  function automatic logic [0:127] rstep(
    input logic [0:127]    s,
    input logic [4:0]      r,
    input logic [0:KS_W-1] ks
  );
    logic [0:127] b;
    logic [0:127] m;
    logic [7:0]   a0, a1, a2, a3;
    b = s;
    if (r != 5'd0 && r <= NR5) begin
      for (int c = 0; c < 4; c++) begin
        for (int w = 0; w < 4; w++) begin
          b[8*(4*c+w) +: 8] =
            sbox(s[8*(4*((c+w)%4)+w) +: 8]);
        end
      end
      if (r != NR5) begin
        m = b;
        for (int c = 0; c < 4; c++) begin
          a0 = b[32*c      +: 8];
          a1 = b[32*c + 8  +: 8];
          a2 = b[32*c + 16 +: 8];
          a3 = b[32*c + 24 +: 8];
          m[32*c +: 8] =
            xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          m[32*c + 8 +: 8] =
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          m[32*c + 16 +: 8] =
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          m[32*c + 24 +: 8] =
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        b = m;
      end
    end
    if (r <= NR5) begin
      b = b ^ ks[128*int'(r) +: 128];
    end
    return b;
  endfunction

  beat_t  beat_d;
  beat_t  main_q;
  beat_t  skid_q;
  state_t state_q;
  logic   valid_q;
  logic   ready_q;

  always_comb begin : p_xf
    logic [4:0]   r;
    logic [0:127] s;
    r = '0;
    s = '0;
    beat_d.data = i_data;
    beat_d.rnd  = '0;
    beat_d.ks   = i_key_schedule;
    beat_d.sb   = i_sideband;
    for (int k = 0; k < NUM_LANES; k++) begin
      r = {1'b0, i_round[4*k +: 4]};
      if (r > NR1) r = NR1;
      s = i_data[128*k +: 128];
      for (int j = 0; j < ROUNDS_PER_STAGE; j++) begin
        s = rstep(s, r, i_key_schedule);
        if (r <= NR5) r = r + 5'd1;
      end
      beat_d.data[128*k +: 128] = s;
      beat_d.rnd[4*k +: 4]      = r[3:0];
    end
  end

  // o_ready is high exactly in EMPTY/ONE, so i_valid alone means accept there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (i_valid) begin
            main_q  <= beat_d;
            valid_q <= 1'b1;
            state_q <= S_ONE;
          end
        end
        S_ONE: begin
          if (i_valid) begin
            if (i_ready) begin
              main_q <= beat_d;
            end else begin
              skid_q  <= beat_d;
              ready_q <= 1'b0;
              state_q <= S_FULL;
            end
          end else if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (i_ready) begin
            main_q  <= skid_q;
            ready_q <= 1'b1;
            state_q <= S_ONE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_EMPTY;
        end
      endcase
    end
  end

  assign o_ready        = ready_q;
  assign o_valid        = valid_q;
  assign o_data         = main_q.data;
  assign o_round        = main_q.rnd;
  assign o_key_schedule = main_q.ks;
  assign o_sideband     = main_q.sb;

endmodule

// File: tb/tb_aes_round_stage.sv
// tb_aes_round_stage: known-answer, mixed-lane, chained, backpressure,
// reset and throughput checks against a byte-level AES model.
`timescale 1ns/1ps
module tb_aes_round_stage;

  localparam int DW  = 384;
  localparam int RW  = 12;
  localparam int KS1 = 1408;
  localparam int SBW = 520;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int tests = 0;
  int fails = 0;

  logic d_iv, d_or, d_ov, d_ir;
  logic [0:DW-1]  d_id, d_od;
  logic [0:RW-1]  d_irn, d_orn;
  logic [0:KS1-1] d_iks, d_oks;
  logic [0:SBW-1] d_isb, d_osb;

  aes_round_stage u_dut (
    .clk(clk), .rst(rst),
    .i_valid(d_iv), .o_ready(d_or),
    .i_data(d_id), .i_round(d_irn),
    .i_key_schedule(d_iks), .i_sideband(d_isb),
    .o_valid(d_ov), .i_ready(d_ir),
    .o_data(d_od), .o_round(d_orn),
    .o_key_schedule(d_oks), .o_sideband(d_osb)
  );

  logic k_iv, k_or, k_ov;
  logic [0:127]   k_id, k_od;
  logic [0:3]     k_irn, k_orn;
  logic [0:KS1-1] k_iks, k_oks;
  logic [0:7]     k_isb, k_osb;

  aes_round_stage #(
    .NUM_LANES(1), .ROUNDS_PER_STAGE(11),
    .KEY_BITS(128), .SIDEBAND_W(8)
  ) u_k128 (
    .clk(clk), .rst(rst),
    .i_valid(k_iv), .o_ready(k_or),
    .i_data(k_id), .i_round(k_irn),
    .i_key_schedule(k_iks), .i_sideband(k_isb),
    .o_valid(k_ov), .i_ready(1'b1),
    .o_data(k_od), .o_round(k_orn),
    .o_key_schedule(k_oks), .o_sideband(k_osb)
  );

  logic m_iv, m_or, m_ov;
  logic [0:DW-1]  m_id, m_od;
  logic [0:RW-1]  m_irn, m_orn;
  logic [0:KS1-1] m_iks, m_oks;
  logic [0:7]     m_isb, m_osb;

  aes_round_stage #(
    .NUM_LANES(3), .ROUNDS_PER_STAGE(5),
    .KEY_BITS(128), .SIDEBAND_W(8)
  ) u_mix (
    .clk(clk), .rst(rst),
    .i_valid(m_iv), .o_ready(m_or),
    .i_data(m_id), .i_round(m_irn),
    .i_key_schedule(m_iks), .i_sideband(m_isb),
    .o_valid(m_ov), .i_ready(1'b1),
    .o_data(m_od), .o_round(m_orn),
    .o_key_schedule(m_oks), .o_sideband(m_osb)
  );

  wire           c_v  [0:15];
  wire           c_r  [0:15];
  wire [0:127]   c_d  [0:15];
  wire [0:3]     c_rn [0:15];
  wire [0:1919]  c_ks [0:15];
  wire [0:7]     c_sb [0:15];
  logic          a_v;
  logic [0:127]  a_d;
  logic [0:1919] a_ks;

  assign c_v[0]  = a_v;
  assign c_d[0]  = a_d;
  assign c_rn[0] = 4'd0;
  assign c_ks[0] = a_ks;
  assign c_sb[0] = 8'h5a;
  assign c_r[15] = 1'b1;

  for (genvar g = 0; g < 15; g++) begin : g_ch
    aes_round_stage #(
      .NUM_LANES(1), .ROUNDS_PER_STAGE(1),
      .KEY_BITS(256), .SIDEBAND_W(8)
    ) u_st (
      .clk(clk), .rst(rst),
      .i_valid(c_v[g]), .o_ready(c_r[g]),
      .i_data(c_d[g]), .i_round(c_rn[g]),
      .i_key_schedule(c_ks[g]), .i_sideband(c_sb[g]),
      .o_valid(c_v[g+1]), .i_ready(c_r[g+1]),
      .o_data(c_d[g+1]), .o_round(c_rn[g+1]),
      .o_key_schedule(c_ks[g+1]), .o_sideband(c_sb[g+1])
    );
  end

  // ---------------- reference model ----------------
  logic [7:0] sb_t [256];

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'd1;
    q = 8'd1;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2)
            ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb_t[p] = x ^ 8'h63;
    end while (p != 8'd1);
    sb_t[0] = 8'h63;
  endtask

  function automatic int gm(int a, int b);
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((b & 1) != 0) p = p ^ a;
      b = b >> 1;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h11b;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(logic [31:0] t);
    return {sb_t[t[31:24]], sb_t[t[23:16]],
            sb_t[t[15:8]], sb_t[t[7:0]]};
  endfunction

  function automatic logic [0:1919] kexp(logic [0:255] key, int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1919] ks;
    int nr;
    nr = nk + 6;
    rc = 8'd1;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = 8'(gm(int'(rc), 2));
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    ks = '0;
    for (int i = 0; i < 4*(nr+1); i++) ks[32*i +: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [0:127] mdl(logic [0:127] in,
      logic [0:1919] ks, int start, int n, int nr);
    int s [16];
    int t [16];
    int a [4];
    int r;
    logic [0:127] o;
    for (int i = 0; i < 16; i++) s[i] = int'(in[8*i +: 8]);
    r = (start > nr + 1) ? nr + 1 : start;
    repeat (n) begin
      if (r <= nr) begin
        if (r > 0) begin
          for (int i = 0; i < 16; i++) t[i] = int'(sb_t[s[i]]);
          for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
              s[4*c+w] = t[4*((c+w)%4)+w];
          if (r < nr) begin
            for (int c = 0; c < 4; c++) begin
              for (int w = 0; w < 4; w++) a[w] = s[4*c+w];
              for (int w = 0; w < 4; w++)
                s[4*c+w] = gm(a[w], 2) ^ gm(a[(w+1)%4], 3)
                         ^ a[(w+2)%4] ^ a[(w+3)%4];
            end
          end
        end
        for (int i = 0; i < 16; i++)
          s[i] = s[i] ^ int'(ks[128*r + 8*i +: 8]);
        r++;
      end
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = 8'(s[i]);
    return o;
  endfunction

  // ---------------- checking helpers ----------------
  typedef struct {
    logic [0:DW-1]  d;
    logic [0:RW-1]  r;
    logic [0:KS1-1] ks;
    logic [0:SBW-1] sb;
  } beat_t;

  beat_t q[$];
  beat_t h;
  logic  hold = 1'b0;
  int    nout = 0;

  task automatic chk(input string tag,
      input logic [519:0] obs, input logic [519:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    logic [0:255]  key;
    logic [0:543]  t;
    logic [0:1919] ks;
    for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
    ks = kexp(key, 4);
    d_iks = ks[0:KS1-1];
    for (int i = 0; i < 12; i++) d_id[32*i +: 32] = $urandom;
    for (int k = 0; k < 3; k++) d_irn[4*k +: 4] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 17; i++) t[32*i +: 32] = $urandom;
    d_isb = t[0:SBW-1];
  endtask

  function automatic beat_t expect_of();
    beat_t e;
    int    st;
    e.ks = d_iks;
    e.sb = d_isb;
    for (int k = 0; k < 3; k++) begin
      st = int'(d_irn[4*k +: 4]);
      e.d[128*k +: 128] = mdl(d_id[128*k +: 128],
                              {d_iks, 512'b0}, st, 1, 10);
      e.r[4*k +: 4] = 4'((st + 1 > 11) ? 11 : st + 1);
    end
    return e;
  endfunction

  task automatic tick();
    beat_t e;
    if (hold) begin
      chk("hold_data", d_od, h.d);
      chk("hold_round", d_orn, h.r);
      chk("hold_ks", 520'(d_oks === h.ks), 520'd1);
      chk("hold_sb", d_osb, h.sb);
    end
    if (d_ov && d_ir) begin
      if (q.size() == 0) begin
        chk("spurious_out", d_ov, 520'd0);
      end else begin
        e = q.pop_front();
        chk("out_data", d_od, e.d);
        chk("out_round", d_orn, e.r);
        chk("out_ks", 520'(d_oks === e.ks), 520'd1);
        chk("out_sb", d_osb, e.sb);
        nout++;
      end
    end
    hold = d_ov && !d_ir;
    h.d = d_od;
    h.r = d_orn;
    h.ks = d_oks;
    h.sb = d_osb;
    if (d_iv && d_or) q.push_back(expect_of());
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:127]  pt;
    logic [0:127]  mid;
    logic [0:127]  r2;
    logic [0:1919] ks;
    logic          acc;
    int            n, j, sc, nacc;

    build_sbox();
    pt = 128'h00112233445566778899aabbccddeeff;
    rst = 1'b1;
    d_iv = 1'b1; d_ir = 1'b0;
    k_iv = 1'b0; m_iv = 1'b0; a_v = 1'b0;
    k_id = '0; k_irn = '0; k_iks = '0; k_isb = '0;
    m_id = '0; m_irn = '0; m_iks = '0; m_isb = '0;
    a_d = '0; a_ks = '0;
    rand_beat();
    step();
    chk("rst_valid", d_ov, 520'd0);
    chk("rst_ready", d_or, 520'd1);
    chk("rst_data", d_od, 520'd0);
    chk("rst_round", d_orn, 520'd0);
    chk("rst_ks", 520'(|d_oks), 520'd0);
    chk("rst_sb", d_osb, 520'd0);
    rst = 1'b0;
    d_iv = 1'b0;
    step();
    chk("idle_valid", d_ov, 520'd0);

    ks = kexp({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    k_iks = ks[0:KS1-1];
    k_id = pt; k_irn = 4'd0; k_isb = 8'hc3;
    k_iv = 1'b1;
    step();
    k_iv = 1'b0;
    chk("k128_valid", k_ov, 520'd1);
    chk("k128_data", k_od, 520'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("k128_round", k_orn, 520'd11);
    chk("k128_sb", k_osb, 520'hc3);
    chk("k128_ks", 520'(k_oks === k_iks), 520'd1);
    chk("k128_ready", k_or, 520'd1);

    mid = mdl(pt, ks, 0, 5, 10);
    for (int i = 0; i < 4; i++) r2[32*i +: 32] = $urandom;
    m_iks = ks[0:KS1-1];
    m_id = {pt, mid, r2};
    m_irn = {4'd0, 4'd5, 4'd11};
    m_isb = 8'h3c;
    m_iv = 1'b1;
    step();
    m_iv = 1'b0;
    chk("mix_valid", m_ov, 520'd1);
    chk("mix_lane0", m_od[0:127], mid);
    chk("mix_lane1", m_od[128:255], mdl(pt, ks, 0, 10, 10));
    chk("mix_lane2", m_od[256:383], r2);
    chk("mix_round", m_orn, 520'h5ab);
    chk("mix_sb", m_osb, 520'h3c);
    chk("mix_ks", 520'(m_oks === m_iks), 520'd1);
    chk("mix_ready", m_or, 520'd1);

    a_ks = kexp(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    a_d = pt;
    chk("chain_ready", c_r[0], 520'd1);
    a_v = 1'b1;
    step();
    a_v = 1'b0;
    n = 1;
    while (!c_v[15] && n < 40) begin
      step();
      n++;
    end
    chk("chain_latency", n, 520'd15);
    chk("chain_data", c_d[15], 520'h8ea2b7ca516745bfeafc49904b496089);
    chk("chain_round", c_rn[15], 520'd15);
    chk("chain_ks", 520'(c_ks[15] === a_ks), 520'd1);
    chk("chain_sb", c_sb[15], 520'h5a);

    // backpressure: i_ready low from the start, released after 3 stalled cycles
    nout = 0;
    d_ir = 1'b0;
    j = 0;
    sc = 0;
    rand_beat();
    d_iv = 1'b1;
    for (int c = 0; c < 60 && j < 4; c++) begin
      if (j >= 2 && !d_ir) begin
        if (sc == 3) begin
          d_ir = 1'b1;
        end else begin
          chk("bp_ready_held", d_or, 520'd0);
          sc++;
        end
      end
      acc = d_iv && d_or;
      tick();
      if (acc) begin
        j++;
        if (j == 2) chk("bp_ready_fall", d_or, 520'd0);
        if (j < 4) rand_beat();
        else d_iv = 1'b0;
      end
    end
    for (int c = 0; c < 10 && q.size() > 0; c++) tick();
    chk("bp_count", nout, 520'd4);
    chk("bp_drained", q.size(), 520'd0);

    // reset while FULL
    d_ir = 1'b0;
    rand_beat();
    d_iv = 1'b1;
    tick();
    rand_beat();
    tick();
    chk("full_ready", d_or, 520'd0);
    rst = 1'b1;
    rand_beat();
    step();
    rst = 1'b0;
    d_iv = 1'b0;
    q.delete();
    hold = 1'b0;
    chk("rstm_valid", d_ov, 520'd0);
    chk("rstm_ready", d_or, 520'd1);
    chk("rstm_data", d_od, 520'd0);
    d_ir = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("rstm_quiet", d_ov, 520'd0);
      tick();
    end

    // back-to-back throughput
    nout = 0;
    nacc = 0;
    rand_beat();
    d_iv = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (d_or) nacc++;
      tick();
      if (c < 99) rand_beat();
      else d_iv = 1'b0;
    end
    chk("tp_accepted", nacc, 520'd100);
    chk("tp_out_99", nout, 520'd99);
    tick();
    chk("tp_out_100", nout, 520'd100);
    chk("tp_empty", d_ov, 520'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
